load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 208 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding data-memory load/store sequencer with lane
//            steering, load extension and request timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_memread,
    input  logic        ex_mem_memwrite,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_aluout1,
    input  logic [31:0] ex_mem_aluout2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        lsu_stall,
    output logic        lsu_load_valid,
    output logic [31:0] lsu_load_data,
    output logic        lsu_misaligned,
    output logic        lsu_bus_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [7:0]  r_cnt;
    logic        r_load_valid;
    logic [31:0] r_load_data;
    logic        r_bus_error;

    logic        w_access;
    logic        w_misaligned;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_extract;
    logic        w_timeout;
    logic        w_start;
    logic        w_load_done;
    logic        w_abort;

    assign w_access  = ex_mem_memread | ex_mem_memwrite;
    assign w_timeout = (r_cnt == C_CNT_LAST);

    // Reserved encodings and unsigned variants on a store are rejected like misalignment
    always_comb begin
        w_misaligned = 1'b0;
        case (ex_mem_funct3)
            3'b000:  w_misaligned = 1'b0;
            3'b001:  w_misaligned = ex_mem_aluout1[0];
            3'b010:  w_misaligned = (ex_mem_aluout1[1:0] != 2'b00);
            3'b100:  w_misaligned = ex_mem_memwrite;
            3'b101:  w_misaligned = ex_mem_memwrite | ex_mem_aluout1[0];
            default: w_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = ex_mem_aluout2;
        case (ex_mem_funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << ex_mem_aluout1[1:0];
                w_wdata = {4{ex_mem_aluout2[7:0]}};
            end
            2'b01: begin
                w_wstrb = ex_mem_aluout1[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex_mem_aluout2[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = ex_mem_aluout2;
            end
        endcase
    end

    assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_extract = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_extract = {24'h000000, w_byte};
            3'b001:  w_extract = {{16{w_half[15]}}, w_half};
            3'b101:  w_extract = {16'h0000, w_half};
            default: w_extract = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        lsu_stall      = 1'b0;
        lsu_misaligned = 1'b0;
        w_start        = 1'b0;
        w_load_done    = 1'b0;
        w_abort        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_misaligned) begin
                        lsu_misaligned = 1'b1;
                    end else begin
                        lsu_stall   = 1'b1;
                        w_start     = 1'b1;
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                lsu_stall = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = r_we ? DONE : WAIT;
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            WAIT: begin
                lsu_stall = 1'b1;
                if (mem_rvalid) begin
                    w_load_done = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= 32'h0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_lane       <= 2'b00;
            r_wdata      <= 32'h0;
            r_wstrb      <= 4'b0000;
            r_cnt        <= 8'h00;
            r_load_valid <= 1'b0;
            r_load_data  <= 32'h0;
            r_bus_error  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_valid <= w_load_done;
            r_bus_error  <= w_abort;
            if (w_start) begin
                r_addr   <= {ex_mem_aluout1[31:2], 2'b00};
                r_we     <= ex_mem_memwrite;
                r_funct3 <= ex_mem_funct3;
                r_lane   <= ex_mem_aluout1[1:0];
                r_wdata  <= ex_mem_memwrite ? w_wdata : 32'h0;
                r_wstrb  <= ex_mem_memwrite ? w_wstrb : 4'b0000;
                r_cnt    <= 8'h00;
            end else if (r_state == REQ || r_state == WAIT) begin
                r_cnt <= r_cnt + 8'h01;
            end
            // A timed-out access reports zero so stale data is never mistaken for a result
            if (w_load_done) begin
                r_load_data <= w_extract;
            end else if (w_abort) begin
                r_load_data <= 32'h0;
            end
        end
    end

    assign mem_req        = (r_state == REQ);
    assign mem_we         = r_we;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign mem_wstrb      = r_wstrb;
    assign lsu_load_valid = r_load_valid;
    assign lsu_load_data  = r_load_data;
    assign lsu_bus_error  = r_bus_error;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Scoreboard bench for load_store_unit with a reactive memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_mem_memread = 1'b0;
    logic        ex_mem_memwrite = 1'b0;
    logic [2:0]  ex_mem_funct3 = 3'b000;
    logic [31:0] ex_mem_aluout1 = 32'h0;
    logic [31:0] ex_mem_aluout2 = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        lsu_stall;
    logic        lsu_load_valid;
    logic [31:0] lsu_load_data;
    logic        lsu_misaligned;
    logic        lsu_bus_error;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_mem_memread  (ex_mem_memread),
        .ex_mem_memwrite (ex_mem_memwrite),
        .ex_mem_funct3   (ex_mem_funct3),
        .ex_mem_aluout1  (ex_mem_aluout1),
        .ex_mem_aluout2  (ex_mem_aluout2),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .lsu_stall       (lsu_stall),
        .lsu_load_valid  (lsu_load_valid),
        .lsu_load_data   (lsu_load_data),
        .lsu_misaligned  (lsu_misaligned),
        .lsu_bus_error   (lsu_bus_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_ld_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ld_seen = 0;
    int          berr_seen = 0;

    // memory-model knobs
    int          ready_dly = 0;
    int          rvalid_dly = 0;
    bit          no_ready = 1'b0;
    logic [31:0] rdata_val = 32'h0;
    int          req_cyc = 0;
    bit          rd_pend = 1'b0;
    int          rd_wait = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic req_t store_model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
        req_t r;
        r.addr = {a[31:2], 2'b00};
        r.we   = 1'b1;
        case (f3[1:0])
            2'b00: begin
                r.strb  = 4'(1 << a[1:0]);
                r.wdata = {24'h0, d[7:0]} * 32'h0101_0101;
            end
            2'b01: begin
                r.strb  = a[1] ? 4'hC : 4'h3;
                r.wdata = {16'h0, d[15:0]} * 32'h0001_0001;
            end
            default: begin
                r.strb  = 4'hF;
                r.wdata = d;
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        b_sh = rd >> (32'(a[1:0]) * 8);
        h_sh = a[1] ? (rd >> 16) : rd;
        case (f3)
            3'b000:  return 32'($signed(b_sh[7:0]));
            3'b100:  return {24'h0, b_sh[7:0]};
            3'b001:  return 32'($signed(h_sh[15:0]));
            3'b101:  return {16'h0, h_sh[15:0]};
            default: return rd;
        endcase
    endfunction

    // Memory responder and output monitor; inputs change on negedge, away from sampling
    always @(negedge clk) begin
        req_t e;
        if (lsu_load_valid) begin
            ld_seen++;
            if (exp_ld_q.size() == 0) check("unexpected_load_valid", 32'd1, 32'd0);
            else check("load_data", lsu_load_data, exp_ld_q.pop_front());
        end
        if (lsu_bus_error) berr_seen++;

        mem_rvalid = 1'b0;
        if (rd_pend) begin
            if (rd_wait == rvalid_dly) begin
                mem_rvalid = 1'b1;
                rd_pend    = 1'b0;
            end else begin
                rd_wait++;
            end
        end
        mem_rdata = mem_rvalid ? rdata_val : 32'hBAD0_BAD0;

        mem_ready = 1'b0;
        if (mem_req) begin
            if (!no_ready && req_cyc == ready_dly) begin
                mem_ready = 1'b1;
                if (exp_req_q.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    e = exp_req_q.pop_front();
                    check("req_addr", mem_addr, e.addr);
                    check("req_we", 32'(mem_we), 32'(e.we));
                    check("req_strb", 32'(mem_wstrb), 32'(e.strb));
                    if (e.we) check("req_wdata", mem_wdata, e.wdata);
                end
                if (!mem_we) begin
                    rd_pend = 1'b1;
                    rd_wait = 0;
                end
            end
            req_cyc++;
        end else begin
            req_cyc = 0;
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int exp_stall, input bit exp_mis, input bit expect_resp);
        int stalls;
        req_t r;
        @(negedge clk);
        ex_mem_memread  = rd;
        ex_mem_memwrite = wr;
        ex_mem_funct3   = f3;
        ex_mem_aluout1  = addr;
        ex_mem_aluout2  = data;
        if (expect_resp) begin
            if (wr) begin
                exp_req_q.push_back(store_model(f3, addr, data));
            end else begin
                r = '{addr: {addr[31:2], 2'b00}, we: 1'b0, strb: 4'h0, wdata: 32'h0};
                exp_req_q.push_back(r);
                exp_ld_q.push_back(load_model(f3, addr, rdata_val));
            end
        end
        #1;
        check("misaligned", 32'(lsu_misaligned), 32'(exp_mis));
        stalls = int'(lsu_stall);
        @(negedge clk);
        ex_mem_memread  = 1'b0;
        ex_mem_memwrite = 1'b0;
        #1;
        if (exp_mis) check("no_req_on_misaligned", 32'(mem_req), 32'd0);
        for (int i = 0; i < 40 && lsu_stall; i++) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        @(negedge clk);
    endtask

    initial begin
        int          ld0;
        int          be0;
        logic [2:0]  f3;
        logic [31:0] a;
        bit          wr;
        logic [2:0]  f3s[5];
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_flags", {29'h0, lsu_load_valid, lsu_bus_error, lsu_stall}, 32'h0);
        check("rst_load_data", lsu_load_data, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // SB to top lane, immediate ready
        ready_dly = 0; rvalid_dly = 0;
        access(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 2, 1'b0, 1'b1);

        // LH / LHU with rvalid two cycles after accept
        rdata_val = 32'h8001_1234; rvalid_dly = 1;
        ld0 = ld_seen;
        access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 4, 1'b0, 1'b1);
        check("lh_value", lsu_load_data, 32'hFFFF_8001);
        check("lh_single_pulse", 32'(ld_seen - ld0), 32'd1);
        access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 4, 1'b0, 1'b1);
        check("lhu_value", lsu_load_data, 32'h0000_8001);
        rvalid_dly = 0;

        // Store leaves load result untouched; read+write together picks the store
        ld0 = ld_seen;
        access(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 1'b1);
        check("load_data_hold", lsu_load_data, 32'h0000_8001);
        check("no_load_on_store", 32'(ld_seen - ld0), 32'd0);

        // Misaligned and reserved encodings
        access(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 1'b1, 1'b0);
        access(1'b1, 1'b0, 3'b001, 32'h0000_2001, 32'h0, 0, 1'b1, 1'b0);
        access(1'b0, 1'b1, 3'b100, 32'h0000_3000, 32'h55, 0, 1'b1, 1'b0);
        access(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 0, 1'b1, 1'b0);
        access(1'b1, 1'b0, 3'b101, 32'h0000_3003, 32'h0, 0, 1'b1, 1'b0);

        // Randomised aligned traffic, kept inside the timeout window
        for (int i = 0; i < 12; i++) begin
            f3 = f3s[$urandom_range(0, 4)];
            wr = 1'($urandom_range(0, 1));
            if (wr && f3[2]) f3 = {1'b0, f3[1:0]};
            a = $urandom;
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            ready_dly  = $urandom_range(0, 1);
            rvalid_dly = (wr || ready_dly != 0) ? 0 : $urandom_range(0, 1);
            rdata_val  = $urandom;
            access(!wr, wr, f3, a, $urandom,
                   wr ? 2 + ready_dly : 3 + ready_dly + rvalid_dly, 1'b0, 1'b1);
        end
        ready_dly = 0; rvalid_dly = 0;

        // Timeout on a load with memory never ready
        rdata_val = 32'h1234_5678;
        access(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 3, 1'b0, 1'b1);
        check("lw_value", lsu_load_data, 32'h1234_5678);
        no_ready = 1'b1;
        be0 = berr_seen;
        ld0 = ld_seen;
        access(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1 + TO, 1'b0, 1'b0);
        no_ready = 1'b0;
        check("bus_error_pulse", 32'(berr_seen - be0), 32'd1);
        check("timeout_load_data", lsu_load_data, 32'h0);
        check("timeout_no_load_valid", 32'(ld_seen - ld0), 32'd0);
        check("timeout_req_dropped", 32'(mem_req), 32'd0);

        // Reset while waiting for read data; the late rvalid must be ignored
        rvalid_dly = 3;
        ld0 = ld_seen;
        @(negedge clk);
        ex_mem_memread = 1'b1; ex_mem_funct3 = 3'b010; ex_mem_aluout1 = 32'h0000_0080;
        exp_req_q.push_back('{addr: 32'h0000_0080, we: 1'b0, strb: 4'h0, wdata: 32'h0});
        @(negedge clk);
        ex_mem_memread = 1'b0;
        @(negedge clk);
        check("stall_in_wait", 32'(lsu_stall), 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_req", 32'(mem_req), 32'd0);
        check("async_rst_stall", 32'(lsu_stall), 32'd0);
        check("async_rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("no_load_after_rst", 32'(ld_seen - ld0), 32'd0);
        check("idle_after_rst", 32'(lsu_stall), 32'd0);
        rvalid_dly = 0;

        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("load_queue_drained", 32'(exp_ld_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
